data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//   Word-addressed data memory for the single-cycle KGP-RISC datapath, sitting behind the ALU address path.
//   Serves load/store instructions: stores write a 32-bit word, and loads return a word through a registered output.
//   Storage is 1024 x 32 bits. All contents are cleared by reset.
// PARAMETERS
//   ADDR_WIDTH  10               word-address width
//   DATA_WIDTH  32               word width in bits
//   DEPTH       2**ADDR_WIDTH    number of words (1024)
// PORTS
//   clk       in   1             system clock; all state updates on its rising edge
//   rst       in   1             reset, asynchronous, active-low; clears all state immediately
//   address   in   ADDR_WIDTH    word address, unsigned, 0..DEPTH-1
//   data_in   in   DATA_WIDTH    write data
//   MemRead   in   1             read enable, active-high
//   MemWrite  in   1             write enable, active-high
//   data_out  out  DATA_WIDTH    registered read data
// BEHAVIOUR
//   - Reset (rst=0, async): every memory word -> 0 and data_out -> 0; held cleared while rst=0, and clk edges are ignored.
//   - Reset release: the first active edge is the first posedge clk with rst=1.
//   - Write: at posedge clk with MemWrite=1, mem[address] <= data_in. The new value is visible to reads from the next edge.
//   - Read: at posedge clk with MemRead=1, data_out <= mem[address]. Latency is 1 cycle, and data_out is valid after the edge.
//   - Idle: MemRead=0 -> data_out holds its last value, whatever the state of address or data_in.
//   - Simultaneous MemRead=1 and MemWrite=1 at the same address:
//       - the write is performed;
//       - data_out gets the OLD word (read-before-write);
//       - the new word is returned by the next read.
//   - Address is full-range; every value 0..1023 is valid, with no wrap or out-of-range case.
//   - X on MemRead/MemWrite is not a legal input; the bench must drive 0/1.
//   - Reset asserted mid-operation aborts any pending write at that edge; memory and data_out read 0 afterwards.
//   - No byte enables and no misalignment handling; the address is a word index.
// STRUCTURE
//   - Shared package kgp_risc_pkg: DATA_WIDTH=32, DMEM_ADDR_WIDTH=10, typedef word_t = logic [31:0].
//   - One sub-module: data_memory_array.
//       - Holds the DEPTH x DATA_WIDTH register array with async clear and the synchronous write port.
//       - Provides a combinational read port.
//   - Top level registers data_out and applies the MemRead gating.
// TESTING
//   1. Reset pulse (rst=0 for 10 ns), then MemRead=1 at address 12 -> data_out=0 one edge later.
//   2. MemWrite=1, address 9, data_in=748; next cycle MemRead=1, address 9 -> data_out=748.
//   3. After 2, MemRead=0 and MemWrite=0, address 14, data_in=543 -> data_out stays 748, and mem[14] stays 0 on a later read.
//   4. Address 0: read -> 0; write data_in=2; read -> 2.
//   5. MemRead=MemWrite=1, address 5, data_in=99 with mem[5]=7 -> data_out=7; next read -> 99.
//   6. Write 1023<-0xDEADBEEF, then assert rst=0 between edges -> data_out=0 immediately; after release, reading 1023 -> 0.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP-RISC datapath.
//   DATA_WIDTH       datapath word width
//   DMEM_ADDR_WIDTH  data-memory word-address width
//   word_t           one datapath word
package kgp_risc_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned DMEM_ADDR_WIDTH = 10;

  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/data_memory_array.sv
// Word storage for the data memory: DEPTH x DATA_WIDTH register array.
// Whole array clears asynchronously on reset; one synchronous write port and
// one combinational read port.
//   clk      in   clock, writes on rising edge
//   rst      in   asynchronous active-low clear of every word
//   we       in   write enable
//   waddr    in   write word address
//   wdata    in   write data
//   raddr    in   read word address
//   rdata    out  current contents of mem[raddr] (combinational)
module data_memory_array #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-edge contents, so a read and write to the same word
  // in one cycle returns the old value.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle KGP-RISC datapath.
// Stores write a full word; loads return a word through a registered output
// (one cycle latency). data_out holds its value whenever MemRead is low.
//   clk       in   clock
//   rst       in   asynchronous active-low reset; clears memory and data_out
//   address   in   word address
//   data_in   in   write data
//   MemRead   in   read enable
//   MemWrite  in   write enable
//   data_out  out  registered read data
module data_memory
  import kgp_risc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = kgp_risc_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  data_memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (MemWrite),
    .waddr (address),
    .wdata (data_in),
    .raddr (address),
    .rdata (rd_data)
  );

  always_comb begin
    data_out_d = data_out_q;
    if (MemRead) begin
      data_out_d = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by random
// load/store traffic compared against an array-based reference model.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [9:0]  address;
  logic [31:0] data_in;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] data_out;

  logic [31:0] model [1024];
  logic [31:0] exp_out;
  int unsigned n_checks;
  int unsigned n_fail;

  data_memory #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_in  (data_in),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = '0;
    exp_out = '0;
  endtask

  // Apply one cycle of inputs, let one rising edge happen, update the model
  // and compare data_out.
  task automatic step(input logic rd, input logic wr, input logic [9:0] a,
                      input logic [31:0] d, input string tag);
    MemRead  = rd;
    MemWrite = wr;
    address  = a;
    data_in  = d;
    @(posedge clk);
    #1;
    if (rd) exp_out = model[a];
    if (wr) model[a] = d;
    check_eq(tag, data_out, exp_out);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    address  = '0;
    data_in  = '0;
    model_clear();

    // 1: reset pulse, then read of a cleared word
    rst = 1'b0;
    #10;
    check_eq("reset_out", data_out, 32'd0);
    rst = 1'b1;
    step(1'b1, 1'b0, 10'd12, 32'd0, "t1_read12");

    // 2: write then read
    step(1'b0, 1'b1, 10'd9, 32'd748, "t2_write9");
    step(1'b1, 1'b0, 10'd9, 32'd0, "t2_read9");
    check_eq("t2_value", data_out, 32'd748);

    // 3: idle holds data_out; no write happens
    step(1'b0, 1'b0, 10'd14, 32'd543, "t3_idle");
    check_eq("t3_hold", data_out, 32'd748);
    step(1'b0, 1'b0, 10'd300, 32'hFFFF_FFFF, "t3_idle2");
    step(1'b1, 1'b0, 10'd14, 32'd0, "t3_read14");
    check_eq("t3_mem14", data_out, 32'd0);

    // 4: address 0 boundary
    step(1'b1, 1'b0, 10'd0, 32'd0, "t4_read0a");
    step(1'b0, 1'b1, 10'd0, 32'd2, "t4_write0");
    step(1'b1, 1'b0, 10'd0, 32'd0, "t4_read0b");
    check_eq("t4_value", data_out, 32'd2);

    // 5: simultaneous read/write returns old word
    step(1'b0, 1'b1, 10'd5, 32'd7, "t5_pre");
    step(1'b1, 1'b1, 10'd5, 32'd99, "t5_rdwr");
    check_eq("t5_old", data_out, 32'd7);
    step(1'b1, 1'b0, 10'd5, 32'd0, "t5_new");
    check_eq("t5_newval", data_out, 32'd99);

    // 6: top address, then asynchronous reset between edges
    step(1'b0, 1'b1, 10'd1023, 32'hDEAD_BEEF, "t6_write1023");
    step(1'b1, 1'b0, 10'd1023, 32'd0, "t6_read1023");
    check_eq("t6_value", data_out, 32'hDEAD_BEEF);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_eq("t6_async_clr", data_out, 32'd0);
    // edge during reset must be ignored
    MemWrite = 1'b1;
    MemRead  = 1'b1;
    address  = 10'd1023;
    data_in  = 32'h1234_5678;
    @(posedge clk);
    #1;
    check_eq("t6_held", data_out, 32'd0);
    #2;
    rst = 1'b1;
    step(1'b1, 1'b0, 10'd1023, 32'd0, "t6_after_rel");
    check_eq("t6_cleared", data_out, 32'd0);
    step(1'b1, 1'b0, 10'd9, 32'd0, "t6_read9");

    // Random traffic; mostly a small address window so reads hit written words
    for (int n = 0; n < 400; n++) begin
      logic        rd;
      logic        wr;
      logic [9:0]  a;
      logic [31:0] d;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 10'($urandom_range(0, 1023));
      else if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'd1023;
      else a = 10'($urandom_range(0, 7));
      d = $urandom;
      step(rd, wr, a, d, "rand");
    end

    // Sweep back over the window so stored values are all read out
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 10'(k), 32'd0, "sweep");
    end
    step(1'b1, 1'b0, 10'd1023, 32'd0, "sweep_top");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
